alu_exec_seq: RTL and testbench
===============================

ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have ports (name direction width meaning):
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-high.
  in_valid  in  1  request present.
  in_ready  out  1  unit can accept a request.
  ALUOp  in  3  main-decoder class: 000 R/I-ALU, 001 load, 010 store, 011 branch, 100 lui.
  funct3  in  3  instruction funct3.
  funct7b5  in  1  instruction bit 30.
  funct7b0  in  1  instruction bit 25 (M-extension select).
  op5  in  1  opcode bit 5 (1 = R-type).
  src_a  in  XLEN  operand A.
  src_b  in  XLEN  operand B or immediate.
  out_valid  out  1  result available.
  out_ready  in  1  consumer takes result.
  result  out  XLEN  registered result.
  zero  out  1  registered (result == 0).
  illegal  out  1  registered undefined-encoding flag.

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-004 SHALL accept a request when in_valid & in_ready; in_valid while not ready is ignored and the operands are not sampled.
REQ-005 SHALL decode ALUOp 000 by funct3: 000 add, or sub only when op5 & funct7b5; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when funct7b5; 110 or; 111 and.
REQ-006 SHALL decode ALUOp 001/010 as add, 011 as sub, 100 as pass src_b; ALUOp 101-111 SHALL give result 0, illegal = 1.
REQ-007 SHALL take the shift amount from src_b[log2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN.
REQ-008 Base ops and illegal encodings SHALL go IDLE -> DONE; out_valid rises the cycle after acceptance.
REQ-009 With ALUOp 000, op5 = 1, funct7b0 = 1, SHALL decode funct3 000-111 as mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-010 M ops SHALL go IDLE -> BUSY; BUSY SHALL perform exactly XLEN iterations (radix-2 shift-add multiply, restoring divide on magnitudes), then DONE; out_valid rises XLEN+1 cycles after acceptance.
REQ-011 Divide by zero SHALL give all-ones for div/divu and src_a for rem/remu; signed overflow (most-negative / -1) SHALL give most-negative for div and 0 for rem.
REQ-012 Signed results SHALL apply sign correction on the BUSY -> DONE transition.
REQ-013 DONE SHALL hold result, zero and illegal stable until out_ready, then go to IDLE; a new request SHALL be accepted no earlier than the cycle after the DONE -> IDLE transition.
REQ-014 zero and illegal SHALL be registered together with result.

Reset
REQ-015 On reset SHALL enter IDLE immediately and asynchronously; result = 0, zero = 0, illegal = 0, out_valid = 0, in_ready = 1 after reset deasserts.
REQ-016 Reset during BUSY or DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-017 Macro ALU_EXEC_MEXT_EN defined: REQ-009 to REQ-012 are present.
REQ-018 Macro ALU_EXEC_MEXT_EN undefined: no BUSY state or multiply/divide datapath is built; M encodings SHALL behave as illegal (result 0, illegal = 1, single-cycle latency).

Verification (XLEN = 32)
REQ-019 add: ALUOp 000, f3 000, op5 1, f7b5 0, a = 5, b = 7 -> next cycle out_valid, result 12, zero 0.
REQ-020 addi with imm bit 5 set: op5 0, f7b5 1, a = 10, b = 0xFFFFFFE0 -> result 0xFFFFFFEA (add, not sub).
REQ-021 sra: f3 101, f7b5 1, a = 0x80000000, b = 0x24 -> result 0xF8000000; srl, same operands -> 0x08000000.
REQ-022 div: a = 0xFFFFFFF9, b = 2 -> result 0xFFFFFFFD, out_valid exactly 33 cycles after acceptance; rem, same operands -> 0xFFFFFFFF; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-023 divu 9 / 0 -> 0xFFFFFFFF; remu 9 % 0 -> 9; div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem, same operands -> 0.
REQ-024 reset asserted 10 cycles into a div -> out_valid never rises; in_ready = 1 after release; separately, out_ready held low 5 cycles in DONE -> result stable and in_ready = 0 throughout.

Source files
------------

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: registered RV ALU behind an in/out valid-ready handshake. Base ops take 1 cycle; M ops take XLEN+1 cycles.
// In DONE the result is held until out_ready is high. The M-extension is enabled with `ALU_EXEC_MEXT_EN; otherwise M encodings are illegal.
module alu_exec_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

`ifdef ALU_EXEC_MEXT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_base_res;
  logic            w_base_ill;
  logic            w_is_m;
  logic [XLEN-1:0] w_acc_res;
  logic            w_acc_ill;

  assign w_shamt = src_b[SHW-1:0];
  assign w_sra   = $signed(src_a) >>> w_shamt;
  assign w_is_m  = (ALUOp == 3'b000) & op5 & funct7b0;

  always_comb begin
    w_base_res = '0;
    w_base_ill = 1'b0;
    case (ALUOp)
      3'b000: begin
        case (funct3)
          3'b000:  w_base_res = (op5 & funct7b5) ? (src_a - src_b) : (src_a + src_b);
          3'b001:  w_base_res = src_a << w_shamt;
          3'b010:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
          3'b011:  w_base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
          3'b100:  w_base_res = src_a ^ src_b;
          3'b101:  w_base_res = funct7b5 ? w_sra : (src_a >> w_shamt);
          3'b110:  w_base_res = src_a | src_b;
          default: w_base_res = src_a & src_b;
        endcase
      end
      3'b001, 3'b010: w_base_res = src_a + src_b;
      3'b011:         w_base_res = src_a - src_b;
      3'b100:         w_base_res = src_b;
      default:        w_base_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MEXT_EN
  assign w_acc_res = w_base_res;
  assign w_acc_ill = w_base_ill;

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [SHW-1:0]    r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_nhi;
  logic [XLEN-1:0]   w_nlo;
  logic [XLEN-1:0]   w_dv;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_m_res;

  // Both multiply and divide run on magnitudes; the sign is restored on the final step
  assign w_sa    = src_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                    (funct3 == 3'b100) | (funct3 == 3'b110));
  assign w_sb    = src_b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110));
  assign w_mag_a = w_sa ? ('0 - src_a) : src_a;
  assign w_mag_b = w_sb ? ('0 - src_b) : src_b;

  always_comb begin
    w_neg = w_sa ^ w_sb;
    case (funct3)
      3'b100:  w_neg = (w_sa ^ w_sb) & (src_b != '0);
      3'b110:  w_neg = w_sa;
      default: w_neg = w_sa ^ w_sb;
    endcase
  end

  // {r_hi,r_lo} is the product shift register for multiply and {remainder,quotient} for divide
  assign w_sum  = {1'b0, r_hi} + {1'b0, ({XLEN{r_lo[0]}} & r_b)};
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = (w_sh >= {1'b0, r_b});
  assign w_diff = w_sh[XLEN-1:0] - r_b;
  assign w_nhi  = r_op[2] ? (w_ge ? w_diff : w_sh[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_nlo  = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};
  assign w_prod = r_neg ? ('0 - {w_nhi, w_nlo}) : {w_nhi, w_nlo};
  assign w_dv   = r_op[1] ? w_nhi : w_nlo;

  always_comb begin
    w_m_res = '0;
    if (r_op[2])
      w_m_res = r_neg ? ('0 - w_dv) : w_dv;
    else if (r_op[1:0] == 2'b00)
      w_m_res = w_prod[XLEN-1:0];
    else
      w_m_res = w_prod[2*XLEN-1:XLEN];
  end
`else
  assign w_acc_res = w_is_m ? '0 : w_base_res;
  assign w_acc_ill = w_is_m | w_base_ill;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_EXEC_MEXT_EN
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
`ifdef ALU_EXEC_MEXT_EN
            if (w_is_m) begin
              r_state <= S_BUSY;
              r_hi    <= '0;
              r_lo    <= w_mag_a;
              r_b     <= w_mag_b;
              r_cnt   <= SHW'(XLEN-1);
              r_op    <= funct3;
              r_neg   <= w_neg;
            end else begin
`else
            begin
`endif
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_acc_res;
              r_zero      <= (w_acc_res == '0);
              r_illegal   <= w_acc_ill;
            end
          end
        end
`ifdef ALU_EXEC_MEXT_EN
        S_BUSY: begin
          r_hi <= w_nhi;
          r_lo <= w_nlo;
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_m_res;
            r_zero      <= (w_m_res == '0);
            r_illegal   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq (XLEN=32): base ops, M ops or their illegal fallback, reset abort, DONE hold.
module tb_alu_exec_seq;
  localparam int XLEN = 32;
`ifdef ALU_EXEC_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam int M_LAT = MEXT ? 33 : 1;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic            op5;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int checks   = 0;
  int failures = 0;

  alu_exec_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .op5(op5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mx(input logic [31:0] v);
    return MEXT ? v : 32'h0;
  endfunction

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] f3,
                        input logic f7b5, input logic f7b0, input logic o5,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    int lat;
    check(tag, "in_ready_idle", in_ready, 1);
    ALUOp = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; op5 = o5;
    src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, "latency", lat, exp_lat);
    check(tag, "result", result, exp_res);
    check(tag, "zero", zero, (exp_res == 32'h0));
    check(tag, "illegal", illegal, exp_ill);
    check(tag, "in_ready_done", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(tag, "out_valid_drop", out_valid, 0);
    check(tag, "in_ready_back", in_ready, 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = '0; funct3 = '0; funct7b5 = 1'b0; funct7b0 = 1'b0; op5 = 1'b0;
    src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset", "result", result, 0);
    check("reset", "zero", zero, 0);
    check("reset", "illegal", illegal, 0);
    check("reset", "out_valid", out_valid, 0);
    check("reset", "in_ready", in_ready, 1);
    @(posedge clk); #1;

    // tag, ALUOp, f3, f7b5, f7b0, op5, a, b, result, illegal, latency
    run_op("add",     3'b000, 3'b000, 0, 0, 1, 32'd5,        32'd7,        32'd12,       0, 1);
    run_op("addi",    3'b000, 3'b000, 1, 0, 0, 32'd10,       32'hFFFFFFE0, 32'hFFFFFFEA, 0, 1);
    run_op("addi_b25",3'b000, 3'b000, 0, 1, 0, 32'd1,        32'h20,       32'h21,       0, 1);
    run_op("sub",     3'b000, 3'b000, 1, 0, 1, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 1);
    run_op("sub_zero",3'b000, 3'b000, 1, 0, 1, 32'd7,        32'd7,        32'h0,        0, 1);
    run_op("sra",     3'b000, 3'b101, 1, 0, 1, 32'h80000000, 32'h24,       32'hF8000000, 0, 1);
    run_op("srl",     3'b000, 3'b101, 0, 0, 1, 32'h80000000, 32'h24,       32'h08000000, 0, 1);
    run_op("sll",     3'b000, 3'b001, 0, 0, 1, 32'd1,        32'h21,       32'd2,        0, 1);
    run_op("slt",     3'b000, 3'b010, 0, 0, 1, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 1);
    run_op("sltu",    3'b000, 3'b011, 0, 0, 1, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 1);
    run_op("xor",     3'b000, 3'b100, 0, 0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 1);
    run_op("or",      3'b000, 3'b110, 0, 0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 1);
    run_op("and",     3'b000, 3'b111, 0, 0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1);
    run_op("load",    3'b001, 3'b010, 0, 0, 0, 32'h1000,     32'h24,       32'h1024,     0, 1);
    run_op("store",   3'b010, 3'b010, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 1);
    run_op("branch",  3'b011, 3'b000, 0, 0, 1, 32'd9,        32'd3,        32'd6,        0, 1);
    run_op("lui",     3'b100, 3'b000, 0, 0, 0, 32'hDEAD,     32'h12345000, 32'h12345000, 0, 1);
    run_op("ill_101", 3'b101, 3'b000, 0, 0, 1, 32'd5,        32'd7,        32'h0,        1, 1);
    run_op("ill_111", 3'b111, 3'b000, 0, 0, 1, 32'd5,        32'd7,        32'h0,        1, 1);

    run_op("mul",     3'b000, 3'b000, 0, 1, 1, 32'hFFFFFFFF, 32'd3,        mx(32'hFFFFFFFD), !MEXT, M_LAT);
    run_op("mulh",    3'b000, 3'b001, 0, 1, 1, 32'd2,        32'h80000000, mx(32'hFFFFFFFF), !MEXT, M_LAT);
    run_op("mulhsu",  3'b000, 3'b010, 0, 1, 1, 32'd2,        32'h80000000, mx(32'h00000001), !MEXT, M_LAT);
    run_op("mulhu",   3'b000, 3'b011, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, mx(32'hFFFFFFFE), !MEXT, M_LAT);
    run_op("div",     3'b000, 3'b100, 0, 1, 1, 32'hFFFFFFF9, 32'd2,        mx(32'hFFFFFFFD), !MEXT, M_LAT);
    run_op("rem",     3'b000, 3'b110, 0, 1, 1, 32'hFFFFFFF9, 32'd2,        mx(32'hFFFFFFFF), !MEXT, M_LAT);
    run_op("divu",    3'b000, 3'b101, 0, 1, 1, 32'd100,      32'd7,        mx(32'd14),       !MEXT, M_LAT);
    run_op("remu",    3'b000, 3'b111, 0, 1, 1, 32'd100,      32'd7,        mx(32'd2),        !MEXT, M_LAT);
    run_op("divu_z",  3'b000, 3'b101, 0, 1, 1, 32'd9,        32'd0,        mx(32'hFFFFFFFF), !MEXT, M_LAT);
    run_op("remu_z",  3'b000, 3'b111, 0, 1, 1, 32'd9,        32'd0,        mx(32'd9),        !MEXT, M_LAT);
    run_op("div_z",   3'b000, 3'b100, 0, 1, 1, 32'hFFFFFFFB, 32'd0,        mx(32'hFFFFFFFF), !MEXT, M_LAT);
    run_op("rem_z",   3'b000, 3'b110, 0, 1, 1, 32'hFFFFFFFB, 32'd0,        mx(32'hFFFFFFFB), !MEXT, M_LAT);
    run_op("div_ovf", 3'b000, 3'b100, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, mx(32'h80000000), !MEXT, M_LAT);
    run_op("rem_ovf", 3'b000, 3'b110, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0,            !MEXT, M_LAT);

    // Reset ten cycles into a divide must discard it
    ALUOp = 3'b000; funct3 = 3'b100; funct7b5 = 1'b0; funct7b0 = 1'b1; op5 = 1'b1;
    src_a = 32'hFFFFFFF9; src_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_busy", "out_valid_async", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_busy", "out_valid_never", seen, 0);
    check("rst_busy", "in_ready", in_ready, 1);
    check("rst_busy", "result", result, 0);
    run_op("add_after_rst", 3'b000, 3'b000, 0, 0, 1, 32'd1, 32'd2, 32'd3, 0, 1);

    // Hold DONE with out_ready low; a competing request must be ignored
    ALUOp = 3'b000; funct3 = 3'b000; funct7b5 = 1'b1; funct7b0 = 1'b0; op5 = 1'b1;
    src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    src_a = 32'd1; src_b = 32'd1; funct7b5 = 1'b0;
    check("hold", "out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold", "result", result, 32'hFFFFFFFE);
      check("hold", "in_ready", in_ready, 0);
      check("hold", "out_valid_held", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold", "out_valid_drop", out_valid, 0);
    check("hold", "in_ready_back", in_ready, 1);
    check("hold", "result_kept", result, 32'hFFFFFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
